usb_rx_ctrl: RTL and testbench
==============================

Name: usb_rx_ctrl

Overview:
- USB receive control unit; sits directly upstream of the PID latch stage and the RX data FIFO.
- Consumes decoded bytes and EOP strobes from the bit-level receiver.
- Checks SYNC, commands the PID latch (PID_clear/PID_mode), and routes payload bytes to the FIFO.
- Enforces per-PID byte counts and reports packet completion or error to the AHB-side protocol logic.

Parameters:
- SYNC_BYTE, 8'h80, required value of the first byte of every packet.
- MAX_DATA, 66, maximum post-PID bytes in a DATA0/DATA1 packet (64 payload + 2 CRC16).
- TOKEN_LEN, 2, exact post-PID byte count for IN/OUT tokens.
- TIMEOUT_CYCLES, 1024, inter-byte timeout (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- byte_valid  input  1  one-cycle strobe: rcv_data holds a new byte this cycle.
- rcv_data  input  8  received byte.
- eop  input  1  one-cycle end-of-packet strobe.
- rx_packet  input  4  PID code from the PID latch stage.
- PID_err  input  1  invalid-PID flag from the PID latch stage.
- fifo_full  input  1  RX FIFO cannot accept a byte.
- PID_clear  output  1  one-cycle clear of the PID latch.
- PID_mode  output  1  one-cycle load of rcv_data into the PID latch.
- store_rx_data  output  1  one-cycle FIFO write strobe; FIFO samples rcv_data.
- rx_transfer_active  output  1  high from SYNC accept to packet end.
- rx_done  output  1  one-cycle pulse: packet ended legally.
- rx_error  output  1  sticky error flag; cleared at the next accepted SYNC.
- rx_byte_count  output  7  post-PID bytes accepted in the current or last packet.

Behaviour:
- Reset (synchronous, active-high; rst takes priority over every input): state IDLE; all outputs 0; rx_byte_count 0. Reset mid-packet aborts the packet silently: no rx_done, no rx_error.
- PID codes on rx_packet: OUT 0001, IN 1001, DATA0 0011, DATA1 1011, ACK 0010.
- IDLE: on byte_valid:
  - rcv_data==SYNC_BYTE: go to WAIT_PID; assert PID_clear for one cycle; set rx_transfer_active; clear rx_error and rx_byte_count.
  - Any other byte: ignored; stay in IDLE.
  - eop in IDLE: ignored.
- WAIT_PID: on byte_valid, assert PID_mode in that same cycle (latch captures it on the next edge) and go to CHK_PID. eop here: set rx_error, go to IDLE.
- CHK_PID: one cycle after the PID load, sample PID_err/rx_packet.
  - PID_err=1: set rx_error, go to ERR_WAIT.
  - DATA0/DATA1: go to DATA.
  - IN/OUT: go to TOKEN.
  - ACK: go to HSHK.
  - A byte_valid arriving in CHK_PID is held one cycle and processed in the next state. The upstream byte spacing is at least 8 cycles, so no second byte can arrive before it is consumed.
- DATA: each byte_valid asserts store_rx_data in the same cycle and increments rx_byte_count.
  - Overflow: a byte arriving with fifo_full=1, or a byte that would make the count exceed MAX_DATA, sets rx_error, is not stored, and moves to ERR_WAIT.
  - eop: rx_done if count>=2, else rx_error; then IDLE.
- TOKEN: bytes are counted only; never stored.
  - A byte that would exceed TOKEN_LEN: rx_error, go to ERR_WAIT.
  - eop: rx_done iff count==TOKEN_LEN, else rx_error; then IDLE.
- HSHK: any byte_valid sets rx_error and moves to ERR_WAIT. eop: rx_done, then IDLE.
- ERR_WAIT: discard all bytes; no store_rx_data. eop: go to IDLE.
- rx_transfer_active falls on the cycle the FSM enters IDLE.
- byte_valid and eop in the same cycle: the byte is processed first (count/store/error), then the eop is evaluated against the updated count.
- rx_byte_count saturates at 127 and holds its last value in IDLE until the next SYNC.

Optional Feature:
- Macro: USB_RX_TIMEOUT_EN.
- With the macro defined:
  - A 10-bit idle counter runs in every non-IDLE state and resets on each byte_valid or eop.
  - When it reaches TIMEOUT_CYCLES: set rx_error, assert PID_clear for one cycle, go to IDLE without rx_done.
- Without the macro: no counter is built, and the FSM waits indefinitely for eop.

Test Plan:
- SYNC 8'h80, PID byte with rx_packet=0011, bytes 8'hA5, 8'h5A, 8'h12, 8'h34, eop -> store_rx_data pulses 4 times; rx_byte_count=4; rx_done=1 for one cycle; rx_error=0.
- SYNC, PID with rx_packet=1001, 2 bytes, eop -> no store_rx_data; rx_done pulse; count=2. Repeat with 3 bytes -> rx_error=1, no rx_done.
- SYNC, PID with PID_err=1, 2 bytes, eop -> rx_error=1; zero stores; return to IDLE. The next SYNC clears rx_error.
- First byte 8'h00, then eop -> FSM stays in IDLE; all outputs 0.
- DATA0 packet with fifo_full=1 at the 3rd payload byte -> exactly 2 stores; rx_error=1; later bytes discarded until eop.
- With USB_RX_TIMEOUT_EN: SYNC, PID=0010, then 1024 idle cycles -> rx_error=1, PID_clear pulse, rx_transfer_active=0. Also assert rst mid-DATA -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/usb_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : usb_rx_ctrl
// Purpose  : USB packet receive control: SYNC check, PID latch control,
//            per-PID byte counting and FIFO write routing.
// Options  : USB_RX_TIMEOUT_EN adds an inter-byte idle timeout.
// Revision : 1.0 - initial release
// ============================================================================
module usb_rx_ctrl #(
    parameter logic [7:0] SYNC_BYTE      = 8'h80,
    parameter int         MAX_DATA       = 66,
    parameter int         TOKEN_LEN      = 2,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] rcv_data,
    input  logic       eop,
    input  logic [3:0] rx_packet,
    input  logic       PID_err,
    input  logic       fifo_full,
    output logic       PID_clear,
    output logic       PID_mode,
    output logic       store_rx_data,
    output logic       rx_transfer_active,
    output logic       rx_done,
    output logic       rx_error,
    output logic [6:0] rx_byte_count
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_PID = 3'd1,
        S_CHK_PID  = 3'd2,
        S_DATA     = 3'd3,
        S_TOKEN    = 3'd4,
        S_HSHK     = 3'd5,
        S_ERR_WAIT = 3'd6
    } state_t;

    localparam logic [3:0] C_PID_OUT   = 4'b0001;
    localparam logic [3:0] C_PID_IN    = 4'b1001;
    localparam logic [3:0] C_PID_DATA0 = 4'b0011;
    localparam logic [3:0] C_PID_DATA1 = 4'b1011;
    localparam logic [3:0] C_PID_ACK   = 4'b0010;
    localparam logic [6:0] C_CNT_MAX   = 7'd127;
    localparam logic [6:0] C_MAX_DATA  = 7'(MAX_DATA);
    localparam logic [6:0] C_TOKEN_LEN = 7'(TOKEN_LEN);

    state_t     r_state;
    logic       r_pend_bv;
    logic       r_pend_eop;
    logic [6:0] r_count;
    logic       r_pid_clear;
    logic       r_active;
    logic       r_done;
    logic       r_error;

    logic       w_bv;
    logic       w_eop;
    logic       w_accept;
    logic       w_reject;
    logic       w_eop_ok;
    logic       w_timeout;
    logic [6:0] w_cnt_inc;
    logic [6:0] w_new_cnt;

    // Byte/eop arriving during CHK_PID are replayed in the following state.
    assign w_bv      = byte_valid | r_pend_bv;
    assign w_eop     = eop | r_pend_eop;
    assign w_cnt_inc = (r_count == C_CNT_MAX) ? r_count : r_count + 7'd1;

    always_comb begin
        w_accept = 1'b0;
        w_reject = 1'b0;
        w_eop_ok = 1'b0;
        case (r_state)
            S_DATA: begin
                w_accept = w_bv && !fifo_full && (r_count < C_MAX_DATA);
                w_reject = w_bv && !w_accept;
            end
            S_TOKEN: begin
                w_accept = w_bv && (r_count < C_TOKEN_LEN);
                w_reject = w_bv && !w_accept;
            end
            S_HSHK: begin
                w_reject = w_bv;
            end
            default: ;
        endcase
        w_new_cnt = w_accept ? w_cnt_inc : r_count;
        case (r_state)
            S_DATA:  w_eop_ok = (w_new_cnt >= 7'd2);
            S_TOKEN: w_eop_ok = (w_new_cnt == C_TOKEN_LEN);
            S_HSHK:  w_eop_ok = 1'b1;
            default: w_eop_ok = 1'b0;
        endcase
    end

    // FIFO and PID latch sample rcv_data in the strobe cycle, so these are Mealy.
    always_comb begin
        store_rx_data = 1'b0;
        PID_mode      = 1'b0;
        if (!rst) begin
            store_rx_data = (r_state == S_DATA) && w_accept;
            PID_mode      = (r_state == S_WAIT_PID) && byte_valid;
        end
    end

`ifdef USB_RX_TIMEOUT_EN
    logic [9:0] r_idle_cnt;

    assign w_timeout = (r_state != S_IDLE) && !byte_valid && !eop &&
                       (r_idle_cnt == 10'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || (r_state == S_IDLE) || byte_valid || eop || w_timeout) begin
            r_idle_cnt <= 10'd0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 10'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pend_bv   <= 1'b0;
            r_pend_eop  <= 1'b0;
            r_count     <= 7'd0;
            r_pid_clear <= 1'b0;
            r_active    <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_pid_clear <= 1'b0;
            r_done      <= 1'b0;
            r_pend_bv   <= 1'b0;
            r_pend_eop  <= 1'b0;
            if (w_timeout) begin
                r_error     <= 1'b1;
                r_pid_clear <= 1'b1;
                r_active    <= 1'b0;
                r_state     <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (byte_valid && (rcv_data == SYNC_BYTE)) begin
                            r_state     <= S_WAIT_PID;
                            r_pid_clear <= 1'b1;
                            r_active    <= 1'b1;
                            r_error     <= 1'b0;
                            r_count     <= 7'd0;
                        end
                    end
                    S_WAIT_PID: begin
                        if (byte_valid) begin
                            r_state    <= S_CHK_PID;
                            r_pend_eop <= eop;
                        end else if (eop) begin
                            r_error  <= 1'b1;
                            r_active <= 1'b0;
                            r_state  <= S_IDLE;
                        end
                    end
                    S_CHK_PID: begin
                        r_pend_bv  <= byte_valid;
                        r_pend_eop <= r_pend_eop | eop;
                        if (PID_err) begin
                            r_error <= 1'b1;
                            r_state <= S_ERR_WAIT;
                        end else begin
                            case (rx_packet)
                                C_PID_DATA0, C_PID_DATA1: r_state <= S_DATA;
                                C_PID_IN, C_PID_OUT:      r_state <= S_TOKEN;
                                C_PID_ACK:                r_state <= S_HSHK;
                                default: begin
                                    r_error <= 1'b1;
                                    r_state <= S_ERR_WAIT;
                                end
                            endcase
                        end
                    end
                    S_DATA, S_TOKEN, S_HSHK: begin
                        r_count <= w_new_cnt;
                        if (w_eop) begin
                            r_state  <= S_IDLE;
                            r_active <= 1'b0;
                            if (!w_reject && w_eop_ok) begin
                                r_done <= 1'b1;
                            end else begin
                                r_error <= 1'b1;
                            end
                        end else if (w_reject) begin
                            r_error <= 1'b1;
                            r_state <= S_ERR_WAIT;
                        end
                    end
                    S_ERR_WAIT: begin
                        if (w_eop) begin
                            r_active <= 1'b0;
                            r_state  <= S_IDLE;
                        end
                    end
                    default: begin
                        r_active <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign PID_clear          = r_pid_clear;
    assign rx_transfer_active = r_active;
    assign rx_done            = r_done;
    assign rx_error           = r_error;
    assign rx_byte_count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_rx_ctrl
// Purpose  : Directed plus randomized packet bench for usb_rx_ctrl with a
//            packet-level outcome model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_rx_ctrl;

    localparam int C_MAX_DATA = 66;

    logic       clk = 1'b0;
    logic       rst;
    logic       byte_valid;
    logic [7:0] rcv_data;
    logic       eop;
    logic [3:0] rx_packet;
    logic       PID_err;
    logic       fifo_full;
    logic       PID_clear;
    logic       PID_mode;
    logic       store_rx_data;
    logic       rx_transfer_active;
    logic       rx_done;
    logic       rx_error;
    logic [6:0] rx_byte_count;

    int n_assert = 0;
    int n_fail   = 0;
    int mon_store = 0;
    int mon_done  = 0;
    int mon_clear = 0;
    int mon_mode  = 0;

    usb_rx_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .byte_valid         (byte_valid),
        .rcv_data           (rcv_data),
        .eop                (eop),
        .rx_packet          (rx_packet),
        .PID_err            (PID_err),
        .fifo_full          (fifo_full),
        .PID_clear          (PID_clear),
        .PID_mode           (PID_mode),
        .store_rx_data      (store_rx_data),
        .rx_transfer_active (rx_transfer_active),
        .rx_done            (rx_done),
        .rx_error           (rx_error),
        .rx_byte_count      (rx_byte_count)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle; the main sequence takes differences.
    always @(negedge clk) begin
        if (store_rx_data === 1'b1) mon_store <= mon_store + 1;
        if (rx_done === 1'b1)       mon_done  <= mon_done + 1;
        if (PID_clear === 1'b1)     mon_clear <= mon_clear + 1;
        if (PID_mode === 1'b1)      mon_mode  <= mon_mode + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic with_eop);
        rcv_data   = b;
        byte_valid = 1'b1;
        eop        = with_eop;
        tick();
        byte_valid = 1'b0;
        eop        = 1'b0;
        repeat (7) tick();
    endtask

    task automatic send_eop();
        eop = 1'b1;
        tick();
        eop = 1'b0;
        repeat (3) tick();
    endtask

    // full_at < 0 means the FIFO never reports full.
    task automatic run_packet(input string tag, input logic [3:0] pid, input logic perr,
                              input int n, input int full_at, input logic eop_last);
        int s0, d0, c0, m0;
        int k, exp_store, exp_cnt;
        logic exp_done, exp_err;
        s0 = mon_store; d0 = mon_done; c0 = mon_clear; m0 = mon_mode;

        send_byte(8'h80, 1'b0);
        check({tag, " active after sync"}, 32'(rx_transfer_active), 1);
        check({tag, " error cleared by sync"}, 32'(rx_error), 0);
        rx_packet = pid;
        PID_err   = perr;
        send_byte({~pid, pid}, 1'b0);
        for (int i = 0; i < n; i++) begin
            fifo_full = (i == full_at);
            send_byte(8'($urandom), eop_last && (i == n - 1));
            fifo_full = 1'b0;
        end
        if (!(eop_last && n > 0)) send_eop();
        repeat (2) tick();

        exp_store = 0; exp_cnt = 0; exp_done = 1'b0; exp_err = 1'b0;
        if (perr) begin
            exp_err = 1'b1;
        end else if (pid == 4'b0011 || pid == 4'b1011) begin
            k = n;
            if (full_at >= 0 && full_at < k) k = full_at;
            if (C_MAX_DATA < k) k = C_MAX_DATA;
            exp_store = k;
            exp_cnt   = k;
            exp_err   = (k < n) || (k < 2);
            exp_done  = !exp_err;
        end else if (pid == 4'b1001 || pid == 4'b0001) begin
            exp_cnt  = (n < 2) ? n : 2;
            exp_done = (n == 2);
            exp_err  = !exp_done;
        end else if (pid == 4'b0010) begin
            exp_done = (n == 0);
            exp_err  = (n != 0);
        end else begin
            exp_err = 1'b1;
        end

        check({tag, " stores"}, 32'(mon_store - s0), 32'(exp_store));
        check({tag, " done pulses"}, 32'(mon_done - d0), 32'(exp_done));
        check({tag, " error"}, 32'(rx_error), 32'(exp_err));
        if (!perr) check({tag, " byte count"}, 32'(rx_byte_count), 32'(exp_cnt));
        check({tag, " active at end"}, 32'(rx_transfer_active), 0);
        check({tag, " pid_clear pulses"}, 32'(mon_clear - c0), 1);
        check({tag, " pid_mode pulses"}, 32'(mon_mode - m0), 1);
    endtask

    initial begin
        logic [3:0] pids [6];
        int d0, c0, waited;
        logic found;
        pids[0] = 4'b0011; pids[1] = 4'b1011; pids[2] = 4'b1001;
        pids[3] = 4'b0001; pids[4] = 4'b0010; pids[5] = 4'b0110;

        rst = 1'b1; byte_valid = 1'b0; rcv_data = 8'h00; eop = 1'b0;
        rx_packet = 4'b0000; PID_err = 1'b0; fifo_full = 1'b0;
        repeat (3) tick();
        check("reset active", 32'(rx_transfer_active), 0);
        check("reset error", 32'(rx_error), 0);
        check("reset count", 32'(rx_byte_count), 0);
        check("reset done", 32'(rx_done), 0);
        check("reset clear", 32'(PID_clear), 0);
        rst = 1'b0;
        tick();

        d0 = mon_done; c0 = mon_clear;
        send_byte(8'h00, 1'b0);
        send_eop();
        check("garbage active", 32'(rx_transfer_active), 0);
        check("garbage error", 32'(rx_error), 0);
        check("garbage count", 32'(rx_byte_count), 0);
        check("garbage no done", 32'(mon_done - d0), 0);
        check("garbage no clear", 32'(mon_clear - c0), 0);

        run_packet("data0 4B", 4'b0011, 1'b0, 4, -1, 1'b0);
        run_packet("in 2B", 4'b1001, 1'b0, 2, -1, 1'b0);
        run_packet("in 3B", 4'b1001, 1'b0, 3, -1, 1'b0);
        run_packet("pid_err", 4'b0011, 1'b1, 2, -1, 1'b0);
        run_packet("data fifo full", 4'b0011, 1'b0, 5, 2, 1'b0);
        run_packet("data 66B", 4'b1011, 1'b0, 66, -1, 1'b1);
        run_packet("data 67B", 4'b0011, 1'b0, 67, -1, 1'b0);
        run_packet("data 1B", 4'b0011, 1'b0, 1, -1, 1'b0);
        run_packet("ack 0B", 4'b0010, 1'b0, 0, -1, 1'b0);

        for (int r = 0; r < 14; r++) begin
            logic [3:0] p;
            logic pe;
            int nb, fa;
            p  = pids[$urandom_range(0, 5)];
            pe = ($urandom_range(0, 7) == 0);
            nb = $urandom_range(0, 8);
            fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            run_packet($sformatf("rand%0d", r), p, pe, nb, fa, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a DATA packet aborts it silently.
        d0 = mon_done;
        send_byte(8'h80, 1'b0);
        rx_packet = 4'b0011; PID_err = 1'b0;
        send_byte(8'hC3, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        rst = 1'b1;
        tick();
        check("midrst active", 32'(rx_transfer_active), 0);
        check("midrst error", 32'(rx_error), 0);
        check("midrst count", 32'(rx_byte_count), 0);
        check("midrst clear", 32'(PID_clear), 0);
        check("midrst store", 32'(store_rx_data), 0);
        rst = 1'b0;
        tick();
        send_eop();
        check("midrst no done", 32'(mon_done - d0), 0);
        check("midrst error after eop", 32'(rx_error), 0);

`ifdef USB_RX_TIMEOUT_EN
        d0 = mon_done;
        send_byte(8'h80, 1'b0);
        rx_packet = 4'b0010; PID_err = 1'b0;
        send_byte(8'h2D, 1'b0);
        found = 1'b0;
        waited = 0;
        while (!found && waited < 1200) begin
            if (PID_clear === 1'b1) found = 1'b1;
            else begin
                tick();
                waited++;
            end
        end
        check("timeout clear pulse seen", 32'(found), 1);
        check("timeout error", 32'(rx_error), 1);
        check("timeout active", 32'(rx_transfer_active), 0);
        check("timeout no done", 32'(mon_done - d0), 0);
`else
        found = 1'b0;
        waited = 0;
        if (found) waited = 1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
